pipelined_adder_tree: RTL
=========================

// Module: pipelined_adder_tree
// PURPOSE
//  Parametrised successor to the fixed 8x8-bit three-stage adder: sums N_IN lanes of DATA_W bits
//  through a registered binary tree of log2(N_IN) stages. Full-precision output, optional signed
//  mode, valid/ready flow control with per-stage bubble collapsing. Sits between a sample source
//  and any downstream consumer that may stall.
// PARAMETERS
//  N_IN     8   lane count; power of two, 2..64
//  DATA_W   8   lane width in bits, 1..32
//  SIGNED   0   0: lanes unsigned, zero-extended; 1: two's complement, sign-extended
//  (local) STAGES = log2(N_IN); OUT_W = DATA_W + STAGES
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous reset, active-low (rst=0 resets)
//  in_valid   in   1              in_data holds a valid vector
//  in_ready   out  1              tree accepts a vector this cycle
//  in_data    in   N_IN*DATA_W    lane i at bits [i*DATA_W +: DATA_W]
//  out_valid  out  1              out_sum valid
//  out_ready  in   1              consumer accepts out_sum this cycle
//  out_sum    out  OUT_W          sum of all lanes of one accepted vector
// BEHAVIOUR
//  - Reset (rst=0, async assert, sync release by clocked logic): all stage valid bits 0, all
//    stage data regs 0; hence out_valid=0, out_sum=0. in_ready=1 as soon as rst=1.
//  - Stage k (k=0..STAGES-1) holds N_IN>>(k+1) partial sums, each DATA_W+k+1 bits, plus vld[k].
//    Stage 0 adds lane pairs (2j, 2j+1) of in_data; stage k adds pairs of stage k-1 entries.
//    Width extension per SIGNED before each add; no carry is ever lost.
//  - Output is stage STAGES-1: out_valid = vld[STAGES-1], out_sum = its single entry.
//  - Advance rule: adv[STAGES-1] = out_ready | ~vld[STAGES-1];
//    adv[k] = adv[k+1] | ~vld[k]. in_ready = adv[0].
//  - Stage k loads when adv[k]: data <= sum of upstream, vld[k] <= upstream valid
//    (in_valid for k=0). When ~adv[k], stage k holds data and vld unchanged.
//  - Transfers: input handshake = in_valid & in_ready; output = out_valid & out_ready.
//  - Latency: STAGES cycles from input handshake to out_valid with no stall (8 lanes: 3).
//  - Throughput: one vector per cycle while out_ready=1.
//  - Bubbles collapse: an invalid stage accepts new data even when downstream is stalled.
//  - out_sum/out_valid stable while out_valid & ~out_ready (no data change until accepted).
//  - in_data ignored when in_valid=0 (stage data may update; vld stays 0, output unaffected).
//  - Simultaneous output accept and input accept in a full pipe: all stages shift, no loss.
//  - Reset mid-operation: in-flight vectors discarded, no out_valid after release until a new
//    vector traverses STAGES stages.
//  - in_ready is combinational from out_ready (through the adv chain); no out_ready->in_ready
//    register slice in this block.
// STRUCTURE
//  - Shared package adder_pkg: clog2 constant function, SUM_W(data_w,n) helper, lane-extract
//    macro/function used by other arithmetic blocks.
//  - One sub-module adder_tree_stage (params N_PAIRS, IN_W, SIGNED): N_PAIRS adders, register
//    bank, vld flop, load enable input. Top instantiates it in a generate loop of STAGES, wires
//    the adv chain, and flattens buses between stages.
// TESTING
//  1 Reset: rst=0 with random in_data/in_valid -> out_valid=0, out_sum=0; after release in_ready=1.
//  2 Latency, 8x8 unsigned: lanes 1..8, one valid cycle, out_ready=1 -> out_sum=36 (11'h024)
//    exactly 3 cycles later, out_valid for one cycle.
//  3 Full-scale: all lanes 8'hFF unsigned -> 11'h7F8; SIGNED=1 all lanes 8'h80 -> 11'h400 (-1024).
//  4 Back-pressure: stream vectors k=0..9 (all lanes=k), out_ready=0 for cycles 4..9 -> in_ready
//    drops after pipe fills (3 held), out_sum held stable, then sums 8k emitted in order, none lost/duplicated.
//  5 Bubble collapse: in_valid alternating 1/0, out_ready=0 -> three vectors absorbed before in_ready=0.
//  6 Reset mid-flight: assert rst=0 with 2 vectors in pipe -> no stale out_valid after release;
//    then lanes 1..8 -> 36; random N_IN=16, DATA_W=12 run vs. reference model, 10k vectors.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared sizing helpers and lane extraction for adder tree blocks
`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV

// Lane i of a flat bus of w-bit lanes; usable on either side of an assignment.
`define ADDER_LANE(bus, i, w) bus[(i)*(w) +: (w)]

package adder_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Full-precision width of a sum of n lanes of data_w bits.
  function automatic int sum_w(input int data_w, input int n);
    return data_w + clog2(n);
  endfunction

  // Bits held by tree stage k: n>>(k+1) partial sums of w+k+1 bits each.
  function automatic int stage_bits(input int n, input int w, input int k);
    return (n >> (k + 1)) * (w + k + 1);
  endfunction

  // Offset of stage k inside the flattened inter-stage bus.
  function automatic int stage_off(input int n, input int w, input int k);
    int off;
    off = 0;
    for (int j = 0; j < k; j++) off += stage_bits(n, w, j);
    return off;
  endfunction

endpackage

`endif

// File: rtl/pipelined_adder_tree_if.sv
// rtl/pipelined_adder_tree_if.sv - vector-in / sum-out handshake bundle for the adder tree
interface pipelined_adder_tree_if
  import adder_pkg::*;
#(
  parameter int N_IN   = 8,
  parameter int DATA_W = 8
);
  localparam int OUT_W = sum_w(DATA_W, N_IN);

  logic                   in_valid;
  logic                   in_ready;
  logic [N_IN*DATA_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_sum;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/adder_tree_stage.sv
// rtl/adder_tree_stage.sv - one registered level of the adder tree: N_PAIRS adders plus a valid flop
module adder_tree_stage
  import adder_pkg::*;
#(
  parameter int N_PAIRS = 4,
  parameter int IN_W    = 8,
  parameter int SIGNED  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         up_valid,
  input  logic [2*N_PAIRS*IN_W-1:0]    up_data,
  output logic                         vld,
  output logic [N_PAIRS*(IN_W+1)-1:0]  data
);

  logic [N_PAIRS*(IN_W+1)-1:0] sum;

  for (genvar j = 0; j < N_PAIRS; j++) begin : g_pair
    logic [IN_W-1:0] a;
    logic [IN_W-1:0] b;
    logic [IN_W:0]   ext_a;
    logic [IN_W:0]   ext_b;

    assign a = `ADDER_LANE(up_data, 2*j, IN_W);
    assign b = `ADDER_LANE(up_data, 2*j+1, IN_W);
    // One extra bit per level is exactly enough to keep the carry of a pairwise add.
    assign ext_a = {(SIGNED != 0) & a[IN_W-1], a};
    assign ext_b = {(SIGNED != 0) & b[IN_W-1], b};
    assign `ADDER_LANE(sum, j, IN_W+1) = ext_a + ext_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (load) begin
      vld  <= up_valid;
      data <= sum;
    end
  end

endmodule

// File: rtl/pipelined_adder_tree.sv
// rtl/pipelined_adder_tree.sv - N_IN-lane full-precision registered adder tree with valid/ready flow
module pipelined_adder_tree
  import adder_pkg::*;
#(
  parameter int N_IN   = 8,
  parameter int DATA_W = 8,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_adder_tree_if.slave bus
);

  localparam int STAGES  = clog2(N_IN);
  localparam int OUT_W   = sum_w(DATA_W, N_IN);
  localparam int CHAIN_W = stage_off(N_IN, DATA_W, STAGES);
  localparam int LAST    = stage_off(N_IN, DATA_W, STAGES - 1);

  logic [CHAIN_W-1:0] chain;
  logic [STAGES-1:0]  vld;
  logic [STAGES-1:0]  adv;

  // A stage may load when it is empty or everything below it moves; this collapses bubbles.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = bus.out_ready | ~vld[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) adv[k] = adv[k+1] | ~vld[k];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IN_W    = DATA_W + k;
    localparam int N_PAIRS = N_IN >> (k + 1);
    localparam int OFF     = stage_off(N_IN, DATA_W, k);
    localparam int BITS    = stage_bits(N_IN, DATA_W, k);

    logic [2*N_PAIRS*IN_W-1:0] up_data;
    logic                      up_valid;

    if (k == 0) begin : g_head
      assign up_data  = bus.in_data;
      assign up_valid = bus.in_valid;
    end else begin : g_body
      assign up_data  = chain[stage_off(N_IN, DATA_W, k-1) +: stage_bits(N_IN, DATA_W, k-1)];
      assign up_valid = vld[k-1];
    end

    adder_tree_stage #(
      .N_PAIRS (N_PAIRS),
      .IN_W    (IN_W),
      .SIGNED  (SIGNED)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (adv[k]),
      .up_valid (up_valid),
      .up_data  (up_data),
      .vld      (vld[k]),
      .data     (chain[OFF +: BITS])
    );
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = vld[STAGES-1];
  assign bus.out_sum   = chain[LAST +: OUT_W];

endmodule
